frame_buf_writer: RTL and testbench

FRAME_BUF_WRITER -- requirements
Module: frame_buf_writer

---
 rtl/frame_buf_writer_if.sv | 8 +
 rtl/frame_buf_writer.sv | 111 +++++++++++
 tb/tb_frame_buf_writer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/frame_buf_writer_if.sv
// frame_buf_writer_if: byte-stream handshake feeding the frame buffer writer
interface frame_buf_writer_if;
    logic [7:0] DataIn;
    logic       DataValid;
    logic       DataReady;
    modport master (output DataIn, DataValid, input DataReady);
    modport slave (input DataIn, DataValid, output DataReady);
endinterface

// File: rtl/frame_buf_writer.sv
// frame_buf_writer: packs R,G,B bytes into 24-bit pixels and ping-pongs frames between two display buffers
module frame_buf_writer #(
    parameter int ROWS   = 100,
    parameter int ROW_PX = 4,
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CSDisplay,
    frame_buf_writer_if.slave px,
    input  logic              Buf0Empty,
    input  logic              Buf1Empty,
    output logic              WE0,
    output logic              WE1,
    output logic [ADDR_W-1:0] Addr0,
    output logic [ADDR_W-1:0] Addr1,
    output logic [23:0]       WData,
    output logic [6:0]        row0,
    output logic [6:0]        row1,
    output logic              Buf0Full,
    output logic              Buf1Full
);
    localparam int PX_W  = ROW_PX > 1 ? $clog2(ROW_PX) : 1;
    localparam int FRAME = ROWS * ROW_PX;

    typedef enum logic [1:0] {WAIT0, FILL0, WAIT1, FILL1} state_t;

    state_t            state_q;
    logic [1:0]        comp_q;
    logic [PX_W-1:0]   pix_q;
    logic [7:0]        r_q, g_q;
    logic              we0_q, we1_q, full0_q, full1_q;
    logic [ADDR_W-1:0] addr0_q, addr1_q;
    logic [23:0]       wdata_q;
    logic [6:0]        row0_q, row1_q;
    logic              acc, pix_done, row_done, frame_done;

    assign px.DataReady = (state_q == FILL0 || state_q == FILL1) && CSDisplay;
    assign acc          = px.DataValid && px.DataReady;
    assign pix_done     = acc && comp_q == 2'd2;
    assign row_done     = pix_done && pix_q == PX_W'(ROW_PX - 1);
    assign frame_done   = row_done && (state_q == FILL1 ? row1_q : row0_q) == 7'(ROWS - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= WAIT0;
            comp_q  <= '0;
            pix_q   <= '0;
            r_q     <= '0;
            g_q     <= '0;
            we0_q   <= 1'b0;
            we1_q   <= 1'b0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            addr0_q <= '0;
            addr1_q <= '0;
            wdata_q <= '0;
            row0_q  <= '0;
            row1_q  <= '0;
        end else begin
            we0_q <= pix_done && state_q == FILL0;
            we1_q <= pix_done && state_q == FILL1;
            // address advances once the strobe has been presented, so WEx sees the pre-increment value
            if (we0_q) addr0_q <= addr0_q == ADDR_W'(FRAME - 1) ? '0 : addr0_q + ADDR_W'(1);
            if (we1_q) addr1_q <= addr1_q == ADDR_W'(FRAME - 1) ? '0 : addr1_q + ADDR_W'(1);
            if (acc) comp_q <= pix_done ? 2'd0 : comp_q + 2'd1;
            if (acc && comp_q == 2'd0) r_q <= px.DataIn;
            if (acc && comp_q == 2'd1) g_q <= px.DataIn;
            if (pix_done) begin
                wdata_q <= {r_q, g_q, px.DataIn};
                pix_q   <= row_done ? '0 : pix_q + PX_W'(1);
            end
            if (row_done && !frame_done && state_q == FILL0) row0_q <= row0_q + 7'd1;
            if (row_done && !frame_done && state_q == FILL1) row1_q <= row1_q + 7'd1;
            if (frame_done && state_q == FILL0) begin
                full0_q <= 1'b1;
                state_q <= WAIT1;
            end
            if (frame_done && state_q == FILL1) begin
                full1_q <= 1'b1;
                state_q <= WAIT0;
            end
            if (CSDisplay && state_q == WAIT0 && Buf0Empty) begin
                state_q <= FILL0;
                full0_q <= 1'b0;
                row0_q  <= '0;
                addr0_q <= '0;
                pix_q   <= '0;
                comp_q  <= '0;
            end
            if (CSDisplay && state_q == WAIT1 && Buf1Empty) begin
                state_q <= FILL1;
                full1_q <= 1'b0;
                row1_q  <= '0;
                addr1_q <= '0;
                pix_q   <= '0;
                comp_q  <= '0;
            end
        end
    end

    assign WE0      = we0_q;
    assign WE1      = we1_q;
    assign Addr0    = addr0_q;
    assign Addr1    = addr1_q;
    assign WData    = wdata_q;
    assign row0     = row0_q;
    assign row1     = row1_q;
    assign Buf0Full = full0_q;
    assign Buf1Full = full1_q;
endmodule

// File: tb/tb_frame_buf_writer.sv
// tb_frame_buf_writer: random and directed stimulus against a pixel-count reference model
module tb_frame_buf_writer;
    localparam int ROWS   = 100;
    localparam int ROW_PX = 4;
    localparam int ADDR_W = 9;
    localparam int FRAME  = ROWS * ROW_PX;

    logic              clock = 1'b0;
    logic              reset, CSDisplay, Buf0Empty, Buf1Empty;
    logic              WE0, WE1, Buf0Full, Buf1Full;
    logic [ADDR_W-1:0] Addr0, Addr1;
    logic [23:0]       WData;
    logic [6:0]        row0, row1;

    frame_buf_writer_if bus();

    frame_buf_writer #(.ROWS(ROWS), .ROW_PX(ROW_PX), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .CSDisplay(CSDisplay), .px(bus),
        .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty), .WE0(WE0), .WE1(WE1),
        .Addr0(Addr0), .Addr1(Addr1), .WData(WData), .row0(row0), .row1(row1),
        .Buf0Full(Buf0Full), .Buf1Full(Buf1Full)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model tracks which buffer is filling and how many bytes/pixels it has taken
    bit         filling;
    int         bsel, nb, npix;
    logic [7:0] mr, mg;
    bit         m_full[2];
    bit         m_we[2];
    int         m_row[2];
    int         m_addr[2];
    logic [23:0] m_wd;

    function automatic void model(input bit rs, input bit cs, input bit v, input bit e0, input bit e1,
                                  input logic [7:0] d);
        bit acc;
        if (rs) begin
            filling = 0; bsel = 0; nb = 0; npix = 0; mr = 0; mg = 0; m_wd = 0;
            for (int b = 0; b < 2; b++) begin
                m_full[b] = 0; m_we[b] = 0; m_row[b] = 0; m_addr[b] = 0;
            end
            return;
        end
        acc = filling && cs && v;
        for (int b = 0; b < 2; b++) begin
            if (m_we[b]) m_addr[b] = (m_addr[b] + 1) % FRAME;
            m_we[b] = 0;
        end
        if (!filling && cs && (bsel == 1 ? e1 : e0)) begin
            filling = 1; nb = 0; npix = 0;
            m_full[bsel] = 0; m_row[bsel] = 0; m_addr[bsel] = 0;
        end else if (acc) begin
            if (nb == 0) mr = d;
            else if (nb == 1) mg = d;
            else begin
                m_wd = {mr, mg, d};
                m_we[bsel] = 1;
                npix++;
                m_row[bsel] = npix / ROW_PX < ROWS ? npix / ROW_PX : ROWS - 1;
                if (npix == FRAME) begin
                    m_full[bsel] = 1;
                    filling = 0;
                    bsel = 1 - bsel;
                end
            end
            nb = (nb + 1) % 3;
        end
    endfunction

    task automatic cyc(input bit rs, input bit cs, input bit v, input bit e0, input bit e1, input logic [7:0] d);
        reset = rs; CSDisplay = cs; bus.DataValid = v; bus.DataIn = d; Buf0Empty = e0; Buf1Empty = e1;
        #1;
        chk("ready", bus.DataReady, filling && cs);
        model(rs, cs, v, e0, e1, d);
        @(negedge clock);
        chk("we0", WE0, m_we[0]);
        chk("we1", WE1, m_we[1]);
        chk("wdata", WData, m_wd);
        chk("addr0", Addr0, m_addr[0]);
        chk("addr1", Addr1, m_addr[1]);
        chk("row0", row0, m_row[0]);
        chk("row1", row1, m_row[1]);
        chk("full0", Buf0Full, m_full[0]);
        chk("full1", Buf1Full, m_full[1]);
    endtask

    task automatic pixels(input int n, input bit e0, input bit e1);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 3; k++) cyc(0, 1, 1, e0, e1, 8'($urandom));
    endtask

    initial begin
        reset = 1; CSDisplay = 0; bus.DataValid = 0; bus.DataIn = 0; Buf0Empty = 0; Buf1Empty = 0;
        repeat (2) @(negedge clock);
        model(1, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'h11);
        cyc(0, 1, 1, 0, 0, 8'h22);
        cyc(0, 1, 1, 0, 0, 8'h33);
        chk("first_we0", WE0, 1);
        chk("first_wdata", WData, 24'h112233);
        chk("first_addr", Addr0, 0);
        cyc(0, 1, 0, 0, 0, 8'h00);
        chk("first_single_pulse", WE0, 0);
        chk("first_addr_inc", Addr0, 1);
        pixels(FRAME - 1, 0, 0);
        chk("frame0_row", row0, 99);
        chk("frame0_full", Buf0Full, 1);
        chk("frame0_last_addr", Addr0, FRAME - 1);
        repeat (4) cyc(0, 1, 1, 0, 0, 8'hAA);
        chk("wait1_ready", bus.DataReady, 0);
        cyc(0, 1, 0, 0, 1, 8'h00);
        pixels(FRAME, 1, 0);
        chk("frame1_full", Buf1Full, 1);
        chk("frame1_last_addr", Addr1, FRAME - 1);
        cyc(0, 1, 0, 1, 0, 8'h00);
        chk("buf0_full_clear", Buf0Full, 0);
        chk("row0_clear", row0, 0);
        cyc(0, 1, 1, 0, 0, 8'hA1);
        repeat (5) cyc(0, 0, 1, 1, 1, 8'hEE);
        cyc(0, 1, 1, 0, 0, 8'hB2);
        cyc(0, 1, 1, 0, 0, 8'hC3);
        chk("cs_hold_pixel", WData, 24'hA1B2C3);
        chk("cs_hold_addr", Addr0, 0);
        cyc(1, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 1, 0, 8'h00);
        pixels(37, 0, 0);
        cyc(0, 1, 1, 0, 0, 8'h5A);
        cyc(0, 1, 1, 0, 0, 8'h6B);
        cyc(1, 1, 1, 0, 0, 8'h7C);
        chk("reset_mid_row0", row0, 0);
        cyc(0, 1, 1, 0, 0, 8'h7C);
        chk("reset_no_we0", WE0, 0);
        cyc(0, 1, 0, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 0, 8'h01);
        cyc(0, 1, 1, 0, 0, 8'h02);
        cyc(0, 1, 1, 0, 0, 8'h03);
        chk("restart_wdata", WData, 24'h010203);
        chk("restart_addr", Addr0, 0);
        for (int i = 0; i < 20000; i++)
            cyc($urandom_range(0, 2999) == 0, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 8'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
